if_id_hazard: RTL
=================

IF_ID_HAZARD -- requirements
Module: if_id_hazard

Interface
REQ-001 Parameter: size, default 32, datapath and PC width.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous, active-low.
REQ-004 instr_IF  input  size  instruction word returned by instruction memory for PC_IF.
REQ-005 branch_taken_EX  input  1  taken branch/jump resolved in EX this cycle.
REQ-006 branch_target_EX  input  size  redirect address, valid when branch_taken_EX=1.
REQ-007 MemRead_EX  input  1  instruction in EX is a load.
REQ-008 wrin_EX  input  5  destination register of instruction in EX.
REQ-009 PC_IF  output  size  fetch address to instruction memory (registered).
REQ-010 PC_ID  output  size  PC of instruction held in ID (registered).
REQ-011 instr_ID  output  size  instruction held in ID (registered).
REQ-012 valid_ID  output  1  instr_ID is a real instruction, not a flush/reset NOP (registered).
REQ-013 stall_ID  output  1  load-use hazard detected this cycle (combinational).
REQ-014 bubble_ID  output  1  ID must drive all-zero control into the ID/EX register this cycle (combinational).
REQ-015 stall_cnt  output  16  saturating count of stall cycles.
REQ-016 flush_cnt  output  16  saturating count of branch redirects.

Function
REQ-017 rs1_ID = instr_ID[19:15], rs2_ID = instr_ID[24:20], opcode = instr_ID[6:0].
REQ-018 uses_rs1 SHALL be 1 except for opcodes 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL).
REQ-019 uses_rs2 SHALL be 1 only for opcodes 0110011 (R), 0100011 (S), 1100011 (B).
REQ-020 stall_ID = valid_ID & MemRead_EX & (wrin_EX != 0) & ((uses_rs1 & wrin_EX==rs1_ID) | (uses_rs2 & wrin_EX==rs2_ID)) & !branch_taken_EX.
REQ-021 bubble_ID = stall_ID | branch_taken_EX | !valid_ID.
REQ-022 Priority each edge: branch_taken_EX > stall_ID > normal advance.
REQ-023 Redirect: PC_IF <= branch_target_EX; instr_ID <= 0x00000013; PC_ID <= 0; valid_ID <= 0.
REQ-024 Stall: PC_IF, PC_ID, instr_ID, valid_ID SHALL hold their values (exactly one cycle per load-use, since the load leaves EX next edge).
REQ-025 Advance: PC_IF <= PC_IF + 4 (modulo 2^size, 0xFFFFFFFC wraps to 0); instr_ID <= instr_IF; PC_ID <= PC_IF; valid_ID <= 1.
REQ-026 stall_cnt SHALL increment on each edge where stall_ID=1; flush_cnt on each edge where branch_taken_EX=1; both saturate at 0xFFFF, no wrap.
REQ-027 branch_target_EX SHALL be used unaligned as given; no alignment check.
REQ-028 Latency: instruction fetched at PC_IF appears on instr_ID one edge later if not stalled/flushed.

Reset
REQ-029 RESET_N=0 SHALL immediately force PC_IF=0, PC_ID=0, instr_ID=0x00000013, valid_ID=0, stall_cnt=0, flush_cnt=0, independent of CLK.
REQ-030 While valid_ID=0, bubble_ID=1 and stall_ID=0.
REQ-031 Reset assertion mid-stall or mid-redirect SHALL discard the pending action; first edge after release performs a normal advance from PC_IF=0.

Verification
REQ-032 Reset release, instr_IF=0x00500093 constant, no hazards -> edges 1..3: PC_IF=4,8,12; PC_ID=0,4,8; valid_ID=1 from edge 1; bubble_ID=0 from edge 1.
REQ-033 instr_ID=0x002081B3 (add x3,x1,x2), MemRead_EX=1, wrin_EX=2 -> stall_ID=1, bubble_ID=1; next edge PC_IF/PC_ID/instr_ID unchanged, stall_cnt=1; with wrin_EX=0 -> stall_ID=0.
REQ-034 instr_ID=0x000011B7 (LUI x3), MemRead_EX=1, wrin_EX=0 or rs1 field match -> stall_ID=0.
REQ-035 branch_taken_EX=1, branch_target_EX=0x40, simultaneous load-use condition -> stall_ID=0, bubble_ID=1; next edge PC_IF=0x40, instr_ID=0x00000013, valid_ID=0, flush_cnt=1, stall_cnt unchanged.
REQ-036 PC_IF=0xFFFFFFFC, advance -> PC_IF=0; stall held 0x10000 cycles -> stall_cnt=0xFFFF and stays.
REQ-037 RESET_N pulsed low between edges during a stall -> outputs at reset values immediately, counters 0, next edge PC_IF=4.

Source files
------------

// File: rtl/if_id_hazard.sv
// IF/ID stage with load-use stall detection and branch-redirect flush.
// Holds the fetch PC and the ID-stage instruction; counts stall and flush cycles.
module if_id_hazard #(
    parameter int size = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [size-1:0] instr_IF,
    input  logic            branch_taken_EX,
    input  logic [size-1:0] branch_target_EX,
    input  logic            MemRead_EX,
    input  logic [4:0]      wrin_EX,
    output logic [size-1:0] PC_IF,
    output logic [size-1:0] PC_ID,
    output logic [size-1:0] instr_ID,
    output logic            valid_ID,
    output logic            stall_ID,
    output logic            bubble_ID,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
);
    localparam logic [size-1:0] NOP = size'(32'h0000_0013);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    logic [size-1:0] pc_if_q, pc_if_d;
    logic [size-1:0] pc_id_q, pc_id_d;
    logic [size-1:0] instr_id_q, instr_id_d;
    logic            valid_id_q, valid_id_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic [15:0]     flush_cnt_q, flush_cnt_d;

    logic [6:0] opcode;
    logic [4:0] rs1_id, rs2_id;
    logic       uses_rs1, uses_rs2, rs_hit, stall;

    assign opcode = instr_id_q[6:0];
    assign rs1_id = instr_id_q[19:15];
    assign rs2_id = instr_id_q[24:20];

    always_comb begin
        uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        uses_rs2 = (opcode == OP_R || opcode == OP_S || opcode == OP_B);
        rs_hit   = (uses_rs1 && wrin_EX == rs1_id) || (uses_rs2 && wrin_EX == rs2_id);
        // A redirect squashes the ID instruction, so stalling it would be pointless.
        stall    = valid_id_q && MemRead_EX && (wrin_EX != 5'd0) && rs_hit && !branch_taken_EX;
    end

    always_comb begin
        pc_if_d    = pc_if_q;
        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;
        valid_id_d = valid_id_q;
        if (branch_taken_EX) begin
            pc_if_d    = branch_target_EX;
            pc_id_d    = '0;
            instr_id_d = NOP;
            valid_id_d = 1'b0;
        end else if (!stall) begin
            pc_if_d    = pc_if_q + size'(4);
            pc_id_d    = pc_if_q;
            instr_id_d = instr_IF;
            valid_id_d = 1'b1;
        end
        stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        flush_cnt_d = (branch_taken_EX && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_if_q     <= '0;
            pc_id_q     <= '0;
            instr_id_q  <= NOP;
            valid_id_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_if_q     <= pc_if_d;
            pc_id_q     <= pc_id_d;
            instr_id_q  <= instr_id_d;
            valid_id_q  <= valid_id_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC_IF     = pc_if_q;
    assign PC_ID     = pc_id_q;
    assign instr_ID  = instr_id_q;
    assign valid_ID  = valid_id_q;
    assign stall_ID  = stall;
    assign bubble_ID = stall || branch_taken_EX || !valid_id_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule
